// File: rtl/mem_access_ctrl.sv
// Load/store unit bus controller: accepts one decoded memory op, runs a single
// data-bus transfer with timeout, formats the load result and flags faults.

package mem_types_pkg;
  typedef enum logic [3:0] {
    memop_nop = 4'd0,
    l_byte    = 4'd1,
    l_hword   = 4'd2,
    l_word    = 4'd3,
    l_ubyte   = 4'd4,
    l_uhword  = 4'd5,
    s_byte    = 4'd6,
    s_hword   = 4'd7,
    s_word    = 4'd8
  } rv32_memop;
endpackage

module mem_access_ctrl
  import mem_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  rv32_memop   i_memop,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic [1:0]  o_dbg_state
);

  // Handshake: an op transfers on a rising edge where i_valid && o_ready and
  // i_memop != memop_nop; o_ready is high only in IDLE. The bus request is
  // held with stable addr/we/be/wdata until the edge on which i_bus_ack is 1.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  rv32_memop   op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [15:0] wait_q;
  logic        fault_to_q;

  logic        accept;
  logic        in_misaligned;
  logic        wait_expired;

  function automatic logic is_store(input rv32_memop op);
    return (op == s_byte) || (op == s_hword) || (op == s_word);
  endfunction

  function automatic logic is_misaligned(input rv32_memop op, input logic [1:0] a);
    logic m;
    case (op)
      l_hword, l_uhword, s_hword: m = a[0];
      l_word, s_word:             m = (a != 2'b00);
      default:                    m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] store_be(input rv32_memop op, input logic [1:0] a);
    logic [3:0] be;
    case (op)
      s_byte:  be = 4'b0001 << a;
      s_hword: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input rv32_memop op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      s_byte:  r = {4{d[7:0]}};
      s_hword: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Lane select first, then extend according to the load flavour.
  function automatic logic [31:0] load_result(input rv32_memop op, input logic [1:0] lane,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (op)
      l_byte:   r = {{24{b[7]}}, b};
      l_ubyte:  r = {24'h0, b};
      l_hword:  r = {{16{h[15]}}, h};
      l_uhword: r = {16'h0, h};
      l_word:   r = d;
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

  assign accept        = (state_q == ST_IDLE) && i_valid && (i_memop != memop_nop);
  assign in_misaligned = is_misaligned(i_memop, i_addr[1:0]);
  assign wait_expired  = (wait_q == WAIT_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_misaligned ? ST_FAULT : ST_BUS;
        end
      end
      ST_BUS: begin
        if (i_bus_ack) begin
          state_d = ST_RESP;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: request latch, wait counter, captured load result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q       <= memop_nop;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      wait_q     <= 16'h0;
      fault_to_q <= 1'b0;
    end else begin
      if (accept) begin
        wait_q     <= 16'h0;
        fault_to_q <= 1'b0;
        if (!in_misaligned) begin
          op_q    <= i_memop;
          addr_q  <= i_addr;
          wdata_q <= i_wdata;
        end
      end
      if (state_q == ST_BUS) begin
        if (i_bus_ack) begin
          rdata_q <= load_result(op_q, addr_q[1:0], i_bus_rdata);
        end else begin
          wait_q <= wait_q + 16'd1;
          if (wait_expired) begin
            fault_to_q <= 1'b1;
          end
        end
      end
    end
  end

  // Output logic: everything other than o_ready is gated by state so idle
  // and reset values are all zero.
  always_comb begin
    o_ready      = 1'b0;
    o_bus_req    = 1'b0;
    o_bus_we     = 1'b0;
    o_bus_addr   = 32'h0;
    o_bus_be     = 4'h0;
    o_bus_wdata  = 32'h0;
    o_done       = 1'b0;
    o_rdata      = 32'h0;
    o_misaligned = 1'b0;
    o_timeout    = 1'b0;
    case (state_q)
      ST_IDLE: o_ready = 1'b1;
      ST_BUS: begin
        o_bus_req   = 1'b1;
        o_bus_we    = is_store(op_q);
        o_bus_addr  = {addr_q[31:2], 2'b00};
        o_bus_be    = is_store(op_q) ? store_be(op_q, addr_q[1:0]) : 4'b1111;
        o_bus_wdata = store_data(op_q, wdata_q);
      end
      ST_RESP: begin
        o_done  = 1'b1;
        o_rdata = rdata_q;
      end
      ST_FAULT: begin
        o_misaligned = !fault_to_q;
        o_timeout    = fault_to_q;
      end
      default: o_ready = 1'b0;
    endcase
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset/back-to-back
// sequences and random ops checked against an arithmetic reference model.

module tb_mem_access_ctrl;
  import mem_types_pkg::*;

  localparam int TO = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  rv32_memop   i_memop;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_timeout;
  logic [1:0]  o_dbg_state;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_memop(i_memop),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
    .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .o_done(o_done), .o_rdata(o_rdata), .o_misaligned(o_misaligned),
    .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    rv32_memop   op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          exp_req_cycles;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_baddr;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdata;
    int          exp_done;
    int          exp_mis;
    int          exp_to;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          req_cycles;
    int          dones;
    int          mis;
    int          tos;
    int          lat;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        unstable;
  } obs_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: every o_done must match the oldest outstanding expectation
  task automatic sb_done(input logic [31:0] act);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected_done actual=0x%08h required=none", act);
    end else begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL sb_rdata actual=0x%08h required=0x%08h", act, e);
      end
    end
  endtask

  function automatic vec_t mk(rv32_memop op, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int delay, int reqc, logic we,
                              logic [3:0] be, logic [31:0] baddr, logic [31:0] bwdata,
                              logic [31:0] rd, int done, int mis, int to, int lat);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
    v.exp_req_cycles = reqc; v.exp_we = we; v.exp_be = be; v.exp_baddr = baddr;
    v.exp_bwdata = bwdata; v.exp_rdata = rd; v.exp_done = done; v.exp_mis = mis;
    v.exp_to = to; v.exp_lat = lat;
    return v;
  endfunction

  // Reference model: access size, lane and extension from plain arithmetic.
  function automatic vec_t model(rv32_memop op, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] rdata, int delay);
    vec_t v;
    int size;
    int lane;
    logic st;
    logic [31:0] x;
    v = mk(op, addr, wdata, rdata, delay, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lane = int'(addr % 32'd4);
    case (op)
      l_byte, l_ubyte, s_byte:    size = 1;
      l_hword, l_uhword, s_hword: size = 2;
      default:                    size = 4;
    endcase
    st = (op == s_byte) || (op == s_hword) || (op == s_word);
    if (op == memop_nop) begin
      v.exp_lat = 0;
    end else if ((lane % size) != 0) begin
      v.exp_mis = 1;
      v.exp_lat = 1;
    end else begin
      v.exp_req_cycles = (delay < TO) ? delay + 1 : TO;
      v.exp_we    = st;
      v.exp_baddr = addr - 32'(lane);
      v.exp_be    = st ? 4'(((1 << size) - 1) << lane) : 4'hF;
      if (size == 1)      v.exp_bwdata = (wdata & 32'hFF) * 32'h0101_0101;
      else if (size == 2) v.exp_bwdata = (wdata & 32'hFFFF) * 32'h0001_0001;
      else                v.exp_bwdata = wdata;
      if (delay < TO) begin
        v.exp_done = 1;
        v.exp_lat  = delay + 2;
        x = rdata >> (8 * lane);
        case (op)
          l_byte:   begin x = x & 32'hFF;   if (x >= 32'h80)   x = x + 32'hFFFF_FF00; end
          l_ubyte:  x = x & 32'hFF;
          l_hword:  begin x = x & 32'hFFFF; if (x >= 32'h8000) x = x + 32'hFFFF_0000; end
          l_uhword: x = x & 32'hFFFF;
          l_word:   x = rdata;
          default:  x = 32'h0;
        endcase
        v.exp_rdata = x;
      end else begin
        v.exp_to  = 1;
        v.exp_lat = TO + 1;
      end
    end
    return v;
  endfunction

  // driver + monitor for one op; starts and ends on a falling edge with o_ready=1
  task automatic run_vec(input vec_t v, input string tag);
    obs_t o;
    o = '{default: '0};
    o.lat = -1;
    chk({tag, ".ready_before"}, 32'(o_ready), 32'd1);
    i_valid     = 1'b1;
    i_memop     = v.op;
    i_addr      = v.addr;
    i_wdata     = v.wdata;
    i_bus_ack   = 1'($urandom_range(0, 1));
    i_bus_rdata = $urandom;
    if (v.exp_done != 0) exp_q.push_back(v.exp_rdata);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_memop = memop_nop;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (o_ready) begin
        o.lat = cyc;
        break;
      end
      if (o_done) begin
        o.dones++;
        sb_done(o_rdata);
      end
      if (o_misaligned) o.mis++;
      if (o_timeout) o.tos++;
      if (o_bus_req) begin
        if (o.req_cycles == 0) begin
          o.we = o_bus_we; o.be = o_bus_be; o.baddr = o_bus_addr; o.bwdata = o_bus_wdata;
        end else if (o.we !== o_bus_we || o.be !== o_bus_be ||
                     o.baddr !== o_bus_addr || o.bwdata !== o_bus_wdata) begin
          o.unstable = 1'b1;
        end
        o.req_cycles++;
        i_bus_ack   = (o.req_cycles == v.delay + 1);
        i_bus_rdata = i_bus_ack ? v.rdata : $urandom;
      end else begin
        i_bus_ack   = 1'($urandom_range(0, 1));
        i_bus_rdata = $urandom;
      end
      @(negedge i_clk);
    end
    i_bus_ack = 1'b0;
    chk({tag, ".latency"}, 32'(o.lat), 32'(v.exp_lat));
    chk({tag, ".req_cycles"}, 32'(o.req_cycles), 32'(v.exp_req_cycles));
    chk({tag, ".done_count"}, 32'(o.dones), 32'(v.exp_done));
    chk({tag, ".misaligned_count"}, 32'(o.mis), 32'(v.exp_mis));
    chk({tag, ".timeout_count"}, 32'(o.tos), 32'(v.exp_to));
    if (v.exp_req_cycles > 0) begin
      chk({tag, ".bus_we"}, 32'(o.we), 32'(v.exp_we));
      chk({tag, ".bus_be"}, 32'(o.be), 32'(v.exp_be));
      chk({tag, ".bus_addr"}, o.baddr, v.exp_baddr);
      chk({tag, ".bus_stable"}, 32'(o.unstable), 32'd0);
      if (v.exp_we) chk({tag, ".bus_wdata"}, o.bwdata, v.exp_bwdata);
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(l_byte,    32'h1003, 32'h0,         32'h80FF_0000, 0, 1, 0, 4'hF, 32'h1000, 32'h0,         32'hFFFF_FF80, 1, 0, 0, 2);
    tbl[1]  = mk(s_hword,   32'h2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 1, 2, 1, 4'hC, 32'h2000, 32'hABCD_ABCD, 32'h0,         1, 0, 0, 3);
    tbl[2]  = mk(l_word,    32'h3001, 32'h0,         32'h0,         0, 0, 0, 4'h0, 32'h0,    32'h0,         32'h0,         0, 1, 0, 1);
    tbl[3]  = mk(l_uhword,  32'h4002, 32'h0,         32'h1111_2222, 9, 4, 0, 4'hF, 32'h4000, 32'h0,         32'h0,         0, 0, 1, 5);
    tbl[4]  = mk(l_uhword,  32'h4002, 32'h0,         32'h8001_1234, 3, 4, 0, 4'hF, 32'h4000, 32'h0,         32'h0000_8001, 1, 0, 0, 5);
    tbl[5]  = mk(memop_nop, 32'h4001, 32'h0,         32'h0,         0, 0, 0, 4'h0, 32'h0,    32'h0,         32'h0,         0, 0, 0, 0);
    tbl[6]  = mk(s_byte,    32'h5003, 32'h0000_00A5, 32'h0,         2, 3, 1, 4'h8, 32'h5000, 32'hA5A5_A5A5, 32'h0,         1, 0, 0, 4);
    tbl[7]  = mk(l_hword,   32'h6000, 32'h0,         32'h0000_F00D, 0, 1, 0, 4'hF, 32'h6000, 32'h0,         32'hFFFF_F00D, 1, 0, 0, 2);
    tbl[8]  = mk(s_word,    32'h7008, 32'hCAFE_F00D, 32'h0,         0, 1, 1, 4'hF, 32'h7008, 32'hCAFE_F00D, 32'h0,         1, 0, 0, 2);
    tbl[9]  = mk(s_hword,   32'h7001, 32'h5555_5555, 32'h0,         0, 0, 0, 4'h0, 32'h0,    32'h0,         32'h0,         0, 1, 0, 1);
    tbl[10] = mk(l_ubyte,   32'h0011, 32'h0,         32'h0000_9C00, 0, 1, 0, 4'hF, 32'h0010, 32'h0,         32'h0000_009C, 1, 0, 0, 2);

    i_rst_n = 1'b0; i_valid = 1'b0; i_memop = memop_nop; i_addr = 32'h0;
    i_wdata = 32'h0; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    #12;
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.bus_req", 32'(o_bus_req), 32'd0);
    chk("rst.bus_be_addr_we", {o_bus_addr[27:0], o_bus_be}, 32'h0);
    chk("rst.bus_wdata", o_bus_wdata, 32'h0);
    chk("rst.flags", {29'h0, o_done, o_misaligned, o_timeout}, 32'h0);
    chk("rst.rdata", o_rdata, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // asynchronous reset in the middle of a bus wait
    begin
      int seen;
      seen = 0;
      i_valid = 1'b1; i_memop = l_word; i_addr = 32'h8000; i_bus_ack = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b0; i_memop = memop_nop;
      chk("rstmid.bus_req_before", 32'(o_bus_req), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("rstmid.bus_req_drop", 32'(o_bus_req), 32'd0);
      chk("rstmid.ready", 32'(o_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
        i_bus_ack = 1'b1;
        @(negedge i_clk);
        if (o_done) seen++;
      end
      chk("rstmid.no_done", 32'(seen), 32'd0);
      i_bus_ack = 1'b0;
      i_rst_n = 1'b1;
      run_vec(mk(l_word, 32'h8004, 32'h0, 32'h1234_5678, 0, 1, 0, 4'hF, 32'h8004, 32'h0,
                 32'h1234_5678, 1, 0, 0, 2), "post_rst");
    end

    // back-to-back with i_valid held high
    begin
      int reqs, dones, early;
      logic prev_ready;
      reqs = 0; dones = 0; early = 0;
      prev_ready = o_ready;
      exp_q.push_back(32'h0000_009C);
      exp_q.push_back(32'h0);
      i_valid = 1'b1; i_memop = l_ubyte; i_addr = 32'h11; i_wdata = 32'h0;
      for (int c = 0; c < 40; c++) begin
        @(negedge i_clk);
        if (o_done) begin
          dones++;
          sb_done(o_rdata);
          if (o_ready) early++;
        end
        if (o_bus_req) begin
          reqs++;
          if (!prev_ready) early++;
          if (reqs == 1) begin
            i_memop = s_word; i_addr = 32'h40; i_wdata = 32'h1122_3344;
          end else begin
            i_valid = 1'b0; i_memop = memop_nop;
            chk("b2b.second_we", 32'(o_bus_we), 32'd1);
            chk("b2b.second_wdata", o_bus_wdata, 32'h1122_3344);
          end
        end
        i_bus_ack = o_bus_req;
        i_bus_rdata = 32'h0000_9C00;
        prev_ready = o_ready;
        if (dones == 2 && o_ready) break;
      end
      i_valid = 1'b0; i_bus_ack = 1'b0;
      chk("b2b.requests", 32'(reqs), 32'd2);
      chk("b2b.completions", 32'(dones), 32'd2);
      chk("b2b.accept_only_when_ready", 32'(early), 32'd0);
    end

    // random ops against the reference model
    for (int i = 0; i < 80; i++) begin
      rv32_memop op;
      logic [31:0] a;
      op = rv32_memop'(4'($urandom_range(0, 8)));
      a = $urandom;
      run_vec(model(op, a, $urandom, $urandom, $urandom_range(0, 5)), $sformatf("rnd%0d", i));
    end

    chk("sb.drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
